alu_issue_stage: RTL

- ID/EX pipeline stage that drives the ALU's opcode and operand interface.
- Decodes the instruction's opcode and funct fields into the 4-bit ALU control code EALUC. Selects and extends the ALU operands EXA/EXB and the destination register.
- Registers all of it in a valid/ready pipeline register, with stall and flush support and an issued-instruction counter.

---
 rtl/alu_issue_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- ID/EX pipeline register feeding the ALU.
//
// Decodes DINST into the 4-bit ALU control code, selects/extends the ALU
// operands and destination register, and registers everything behind a
// valid/ready handshake with stall, flush and an issued-instruction counter.
//
// Ports:
//   CLK, CLRN              clock (rising edge), async active-low reset
//   DINST, DPC, DRS, DRT   instruction, its PC, rs/rt register values
//   DVALID / DREADY        upstream handshake (DREADY = !EVALID | EREADY)
//   FLUSH                  kill registered and incoming instruction
//   EREADY / EVALID        downstream handshake
//   EALUC, EXA, EXB        ALU control code and operands
//   EDST, EWREG, EMEM      destination reg, write enable, 01 load / 10 store
//   EILL                   one-cycle pulse on a dropped illegal instruction
//   ICOUNT                 number of issued instructions (wraps)
module alu_issue_stage #(
    parameter logic [31:0] JAL_OFFSET = 32'd8,
    parameter bit          ILL_BUBBLE = 1'b1
) (
    input  logic        CLK,
    input  logic        CLRN,
    input  logic [31:0] DINST,
    input  logic [31:0] DPC,
    input  logic [31:0] DRS,
    input  logic [31:0] DRT,
    input  logic        DVALID,
    output logic        DREADY,
    input  logic        FLUSH,
    input  logic        EREADY,
    output logic        EVALID,
    output logic [3:0]  EALUC,
    output logic [31:0] EXA,
    output logic [31:0] EXB,
    output logic [4:0]  EDST,
    output logic        EWREG,
    output logic [1:0]  EMEM,
    output logic        EILL,
    output logic [31:0] ICOUNT
);
    localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR   = 4'b0001,
                           ALU_ADD  = 4'b0010, ALU_ADDU = 4'b0011,
                           ALU_JAL  = 4'b0100, ALU_SLTU = 4'b0101,
                           ALU_SUB  = 4'b0110, ALU_SLT  = 4'b0111,
                           ALU_SLL  = 4'b1000, ALU_SRL  = 4'b1001,
                           ALU_NOR  = 4'b1010, ALU_XOR  = 4'b1100,
                           ALU_SUBU = 4'b1110, ALU_LUI  = 4'b1111;

    typedef struct packed {
        logic [3:0]  aluc;
        logic [31:0] exa;
        logic [31:0] exb;
        logic [4:0]  dst;
        logic        wreg;
        logic [1:0]  mem;
    } epay_t;

    logic [5:0]  op, fn;
    logic [31:0] sext, zext;
    epay_t       dec, pay_q;
    logic        legal;
    logic        evalid_q, eill_q, accept;
    logic [31:0] icount_q;
    logic        unused_rs_field;

    assign op   = DINST[31:26];
    assign fn   = DINST[5:0];
    assign sext = {{16{DINST[15]}}, DINST[15:0]};
    assign zext = {16'b0, DINST[15:0]};
    // rs field is consumed upstream as DRS
    assign unused_rs_field = ^DINST[25:21];

    always_comb begin
        dec.aluc = ALU_ADD;
        dec.exa  = DRS;
        dec.exb  = DRT;
        dec.dst  = DINST[15:11];
        dec.wreg = 1'b1;
        dec.mem  = 2'b00;
        legal    = 1'b1;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: dec.aluc = ALU_ADD;
                    6'b100001: dec.aluc = ALU_ADDU;
                    6'b100010: dec.aluc = ALU_SUB;
                    6'b100011: dec.aluc = ALU_SUBU;
                    6'b100100: dec.aluc = ALU_AND;
                    6'b100101: dec.aluc = ALU_OR;
                    6'b100110: dec.aluc = ALU_XOR;
                    6'b100111: dec.aluc = ALU_NOR;
                    6'b101010: dec.aluc = ALU_SLT;
                    6'b101011: dec.aluc = ALU_SLTU;
                    // shifts: value in EXA, shamt rides in EXB[10:6]
                    6'b000000: begin dec.aluc = ALU_SLL; dec.exa = DRT; dec.exb = zext; end
                    6'b000010: begin dec.aluc = ALU_SRL; dec.exa = DRT; dec.exb = zext; end
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000: begin dec.aluc = ALU_ADD;  dec.exb = sext; dec.dst = DINST[20:16]; end
            6'b001001: begin dec.aluc = ALU_ADDU; dec.exb = sext; dec.dst = DINST[20:16]; end
            6'b001010: begin dec.aluc = ALU_SLT;  dec.exb = sext; dec.dst = DINST[20:16]; end
            6'b001011: begin dec.aluc = ALU_SLTU; dec.exb = sext; dec.dst = DINST[20:16]; end
            6'b001100: begin dec.aluc = ALU_AND;  dec.exb = zext; dec.dst = DINST[20:16]; end
            6'b001101: begin dec.aluc = ALU_OR;   dec.exb = zext; dec.dst = DINST[20:16]; end
            6'b001110: begin dec.aluc = ALU_XOR;  dec.exb = zext; dec.dst = DINST[20:16]; end
            6'b001111: begin dec.aluc = ALU_LUI;  dec.exb = zext; dec.dst = DINST[20:16]; end
            6'b100011: begin
                dec.exb = sext; dec.dst = DINST[20:16]; dec.mem = 2'b01;
            end
            6'b101011: begin
                dec.exb = sext; dec.dst = DINST[20:16]; dec.mem = 2'b10; dec.wreg = 1'b0;
            end
            6'b000100, 6'b000101: begin
                dec.aluc = ALU_SUB; dec.dst = DINST[20:16]; dec.wreg = 1'b0;
            end
            6'b000011: begin
                dec.aluc = ALU_JAL; dec.exa = DPC + JAL_OFFSET;
                dec.exb  = 32'b0;   dec.dst = 5'd31;
            end
            default: legal = 1'b0;
        endcase
        // an illegal op that still issues (no bubble) must be harmless
        if (!legal) begin
            dec.aluc = ALU_ADD;
            dec.wreg = 1'b0;
            dec.mem  = 2'b00;
        end
    end

    assign DREADY = !evalid_q | EREADY;
    assign accept = DVALID & DREADY;

    // Payload only loads on accept, and accept is impossible while
    // EVALID & !EREADY, so a stalled instruction is held stable for free.
    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            evalid_q <= 1'b0;
            eill_q   <= 1'b0;
            pay_q    <= '0;
            icount_q <= 32'b0;
        end else begin
            eill_q <= 1'b0;
            if (FLUSH) begin
                evalid_q <= 1'b0;
            end else if (accept) begin
                pay_q    <= dec;
                evalid_q <= legal | !ILL_BUBBLE;
                if (legal || !ILL_BUBBLE) icount_q <= icount_q + 32'd1;
                else                      eill_q   <= 1'b1;
            end else if (EREADY) begin
                evalid_q <= 1'b0;
            end
        end
    end

    assign EVALID = evalid_q;
    assign EALUC  = pay_q.aluc;
    assign EXA    = pay_q.exa;
    assign EXB    = pay_q.exb;
    assign EDST   = pay_q.dst;
    assign EWREG  = pay_q.wreg;
    assign EMEM   = pay_q.mem;
    assign EILL   = eill_q;
    assign ICOUNT = icount_q;
endmodule
